// File: rtl/vga_fb_scheduler.sv
// Frame-buffer RAM arbiter: prefetches one display line into a ping-pong line buffer
// while reserving periodic RAM slots for a valid/ready pixel writer.
module vga_fb_scheduler #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int AW      = 19,
  parameter int DW      = 24,
  parameter int WR_SLOT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_req,
  input  logic [9:0]    line_idx,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lb_we,
  output logic          lb_bank,
  output logic [9:0]    lb_waddr,
  output logic [DW-1:0] lb_wdata,
  output logic          fetch_busy,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic [1:0]    dbg_state
);

  localparam int SW = (WR_SLOT > 1) ? $clog2(WR_SLOT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] base;
  logic [9:0]    rd_cnt;
  logic [SW-1:0] slot_cnt;
  logic          cur_bank;
  logic          s1_rd;
  logic [9:0]    s1_x;
  logic          s1_bank;
  logic          lb_wbank;

  logic          req_ok;
  logic          in_fetch;
  logic          slot_hit;
  logic          grant_wr;
  logic          grant_rd;
  logic          last_rd;
  logic [AW-1:0] rd_addr;

  // Writer handshake: a word transfers in any cycle where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and the writer holds wr_* until accepted.
  always_comb begin
    req_ok   = line_req && (line_idx < 10'(V_ACT));
    in_fetch = (state == S_FETCH);
    slot_hit = (slot_cnt == SW'(WR_SLOT - 1));
    wr_ready = in_fetch ? slot_hit : !line_req;
    grant_wr = wr_valid && wr_ready;
    grant_rd = in_fetch && !grant_wr;
    last_rd  = grant_rd && (rd_cnt == 10'(H_ACT - 1));
    rd_addr  = base + AW'(rd_cnt);
  end

  // Reads that were already in the pipe keep the bank they were issued for.
  assign lb_bank    = lb_we ? lb_wbank : cur_bank;
  assign lb_wdata   = mem_rdata;
  assign fetch_busy = (state != S_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      base      <= '0;
      rd_cnt    <= '0;
      slot_cnt  <= '0;
      cur_bank  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_rd     <= 1'b0;
      s1_x      <= '0;
      s1_bank   <= 1'b0;
      lb_we     <= 1'b0;
      lb_waddr  <= '0;
      lb_wbank  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mem_en <= grant_wr || grant_rd;
      mem_we <= grant_wr;
      if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (grant_rd) begin
        mem_addr <= rd_addr;
      end

      s1_rd    <= grant_rd;
      s1_x     <= rd_cnt;
      s1_bank  <= cur_bank;
      lb_we    <= s1_rd;
      lb_waddr <= s1_x;
      lb_wbank <= s1_bank;

      // A new valid request always restarts the fetch, even mid-line.
      if (req_ok) begin
        state    <= S_FETCH;
        base     <= AW'(line_idx) * AW'(H_ACT);
        rd_cnt   <= '0;
        slot_cnt <= '0;
        cur_bank <= ~cur_bank;
      end else begin
        case (state)
          S_FETCH: begin
            slot_cnt <= slot_hit ? '0 : slot_cnt + SW'(1);
            if (grant_rd) rd_cnt <= rd_cnt + 10'd1;
            if (last_rd) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (!s1_rd) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      if (req_ok && (state != S_IDLE)) overrun <= 1'b1;
      else if (ovr_clr)                overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Scenario bench for vga_fb_scheduler: a behavioural frame RAM plus scoreboards for
// line-buffer writes and RAM writes, driven by one task per scenario.
module tb_vga_fb_scheduler;

  localparam int AW = 19;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_req;
  logic [9:0]    line_idx;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          lb_we;
  logic          lb_bank;
  logic [9:0]    lb_waddr;
  logic [DW-1:0] lb_wdata;
  logic          fetch_busy;
  logic          overrun;
  logic          ovr_clr;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic exp_bank = 1'b0;

  logic [34:0]      exp_q[$];
  logic [AW+DW-1:0] wq[$];

  vga_fb_scheduler dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_idx(line_idx),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank), .lb_waddr(lb_waddr),
    .lb_wdata(lb_wdata), .fetch_busy(fetch_busy), .overrun(overrun), .ovr_clr(ovr_clr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return {a[4:0], a} ^ 24'hA5C3F0;
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= pix(mem_addr);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  function automatic void push_line(input int idx, input logic bank, input int n);
    for (int x = 0; x < n; x++)
      exp_q.push_back({bank, 10'(x), pix(19'(idx * 640 + x))});
  endfunction

  always @(negedge clk) begin : mon
    logic [34:0]      e;
    logic [AW+DW-1:0] w;
    if (lb_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL lb_unexpected: got bank=%0d x=%0d data=%h, required none", lb_bank, lb_waddr, lb_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({lb_bank, lb_waddr, lb_wdata} !== e) begin
          failures++;
          $display("FAIL lb_write: got bank=%0d x=%0d data=%h, required bank=%0d x=%0d data=%h",
                   lb_bank, lb_waddr, lb_wdata, e[34], e[33:24], e[23:0]);
        end
      end
    end
    if (mem_en && mem_we) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL mem_write_unexpected: got addr=%0d, required none", mem_addr);
      end else begin
        w = wq.pop_front();
        if ({mem_addr, mem_wdata} !== w) begin
          failures++;
          $display("FAIL mem_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, w[AW+DW-1:DW], w[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_word(input int k);
    wr_addr = 19'(393216 + k);
    wr_data = 24'($urandom_range(0, 24'hFFFFFF));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; line_req = 1'b0; line_idx = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; ovr_clr = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0)     begin failures++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
    checks++; if (mem_we !== 1'b0)     begin failures++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    checks++; if (mem_addr !== '0)     begin failures++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
    checks++; if (mem_wdata !== '0)    begin failures++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    checks++; if (lb_we !== 1'b0)      begin failures++; $display("FAIL rst_lb_we: got %b required 0", lb_we); end
    checks++; if (lb_bank !== 1'b0)    begin failures++; $display("FAIL rst_lb_bank: got %b required 0", lb_bank); end
    checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", fetch_busy); end
    checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL rst_overrun: got %b required 0", overrun); end
    checks++; if (wr_ready !== 1'b1)   begin failures++; $display("FAIL rst_wr_ready: got %b required 1", wr_ready); end
    next_cycle();
  endtask

  task automatic test_line_fetch();
    int busy = 0, nrd = 0, first = -1, last = -1;
    exp_bank = ~exp_bank;
    push_line(0, exp_bank, 640);
    line_req = 1'b1; line_idx = 10'd0;
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (fetch_busy) busy++;
      if (mem_en && !mem_we) begin
        nrd++;
        if (first < 0) first = c;
        last = c;
      end
    end
    checks++; if (busy != 642)  begin failures++; $display("FAIL fetch_busy_len: got %0d required 642", busy); end
    checks++; if (nrd != 640)   begin failures++; $display("FAIL read_count: got %0d required 640", nrd); end
    checks++; if (first != 2 || last != 641) begin
      failures++; $display("FAIL read_window: got %0d..%0d required 2..641", first, last);
    end
    checks++; if (lb_bank !== 1'b1) begin failures++; $display("FAIL bank_after_line0: got %b required 1", lb_bank); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL line0_left: got %0d pending required 0", exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_writer_slots();
    int k = 0, fetch_acc = 0, bad_slot = 0, last_lb = -1;
    logic acc;
    exp_bank = ~exp_bank;
    push_line(1, exp_bank, 640);
    new_word(k);
    wr_valid = 1'b1;
    line_req = 1'b1; line_idx = 10'd1;
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 760; c++) begin
      @(negedge clk);
      acc = wr_valid && wr_ready;
      if (acc) begin
        wq.push_back({wr_addr, wr_data});
        if (c <= 731) begin
          fetch_acc++;
          if (c % 8 != 0) bad_slot++;
        end
      end
      if (lb_we) last_lb = c;
      next_cycle();
      if (acc) begin k++; new_word(k); end
    end
    wr_valid = 1'b0;
    repeat (3) next_cycle();
    checks++; if (fetch_acc != 91) begin failures++; $display("FAIL slot_writes: got %0d required 91", fetch_acc); end
    checks++; if (bad_slot != 0)   begin failures++; $display("FAIL slot_position: got %0d off-slot required 0", bad_slot); end
    checks++; if (last_lb != 733)  begin failures++; $display("FAIL line1_last_lb: got cycle %0d required 733", last_lb); end
    checks++; if (exp_q.size() != 0 || wq.size() != 0) begin
      failures++; $display("FAIL line1_left: got %0d/%0d pending required 0/0", exp_q.size(), wq.size());
    end
  endtask

  task automatic test_same_cycle();
    int first_acc = -1, we9 = 0;
    logic acc;
    exp_bank = ~exp_bank;
    push_line(5, exp_bank, 640);
    new_word(5000);
    wr_valid = 1'b1;
    line_req = 1'b1; line_idx = 10'd5;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL same_cycle_ready: got %b required 0", wr_ready); end
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      acc = wr_valid && wr_ready;
      if (acc) begin
        wq.push_back({wr_addr, wr_data});
        if (first_acc < 0) first_acc = c;
      end
      if (c == 9) we9 = (mem_en && mem_we) ? 1 : 0;
      if (c > 2 && !fetch_busy) break;
      next_cycle();
      if (acc) wr_valid = 1'b0;
    end
    wr_valid = 1'b0;
    next_cycle();
    checks++; if (first_acc != 8) begin failures++; $display("FAIL first_slot: got cycle %0d required 8", first_acc); end
    checks++; if (we9 != 1)       begin failures++; $display("FAIL slot_write_issue: got %0d required 1", we9); end
    checks++; if (exp_q.size() != 0 || fetch_busy) begin
      failures++; $display("FAIL line5_done: got %0d pending busy=%b required 0/0", exp_q.size(), fetch_busy);
    end
  endtask

  task automatic test_overrun();
    logic old_bank;
    exp_bank = ~exp_bank;
    old_bank = exp_bank;
    push_line(2, old_bank, 100);
    exp_bank = ~exp_bank;
    push_line(3, exp_bank, 640);
    line_req = 1'b1; line_idx = 10'd2;
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      if (c == 100) begin
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early: got %b required 0", overrun); end
      end
      if (c == 101) begin
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_beats_clr: got %b required 1", overrun); end
        checks++; if (!(mem_en && mem_addr == 19'd1379)) begin
          failures++; $display("FAIL last_old_read: got en=%b addr=%0d required 1/1379", mem_en, mem_addr);
        end
        checks++; if (!(lb_we && lb_bank == old_bank)) begin
          failures++; $display("FAIL inflight_bank: got we=%b bank=%b required 1/%b", lb_we, lb_bank, old_bank);
        end
      end
      if (c == 102) begin
        checks++; if (!(mem_en && mem_addr == 19'd1920)) begin
          failures++; $display("FAIL restart_addr: got en=%b addr=%0d required 1/1920", mem_en, mem_addr);
        end
      end
      if (c == 103) begin
        checks++; if (lb_bank !== exp_bank) begin failures++; $display("FAIL new_bank: got %b required %b", lb_bank, exp_bank); end
      end
      if (c > 103 && !fetch_busy) break;
      next_cycle();
      if (c == 99) begin line_req = 1'b1; line_idx = 10'd3; ovr_clr = 1'b1; end
      if (c == 100) begin line_req = 1'b0; ovr_clr = 1'b0; end
    end
    next_cycle();
    checks++; if (exp_q.size() != 0 || fetch_busy) begin
      failures++; $display("FAIL overrun_done: got %0d pending busy=%b required 0/0", exp_q.size(), fetch_busy);
    end
  endtask

  task automatic test_invalid_idx();
    int bad = 0;
    ovr_clr = 1'b1;
    next_cycle();
    ovr_clr = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %b required 0", overrun); end
    next_cycle();
    line_req = 1'b1; line_idx = 10'd480;
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_en || fetch_busy || overrun || lb_bank !== exp_bank) bad++;
      next_cycle();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL invalid_idx: got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_reset_mid();
    exp_bank = ~exp_bank;
    push_line(7, exp_bank, 298);
    line_req = 1'b1; line_idx = 10'd7;
    next_cycle();
    line_req = 1'b0;
    for (int c = 1; c <= 301; c++) begin
      @(negedge clk);
      if (c == 300) begin
        checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL pre_rst_busy: got %b required 1", fetch_busy); end
      end
      if (c == 301) begin
        checks++; if (fetch_busy !== 1'b0 || dbg_state !== 2'd0) begin
          failures++; $display("FAIL rst_mid_state: got busy=%b state=%0d required 0/0", fetch_busy, dbg_state);
        end
        checks++; if (mem_en !== 1'b0 || lb_we !== 1'b0) begin
          failures++; $display("FAIL rst_mid_strobes: got en=%b lb_we=%b required 0/0", mem_en, lb_we);
        end
        checks++; if (lb_bank !== 1'b0) begin failures++; $display("FAIL rst_mid_bank: got %b required 0", lb_bank); end
      end
      if (c < 301) next_cycle();
      if (c == 299) rst = 1'b1;
    end
    next_cycle();
    rst = 1'b0;
    exp_bank = 1'b0;
    repeat (4) next_cycle();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rst_mid_left: got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_line_fetch();
    test_writer_slots();
    test_same_cycle();
    test_overrun();
    test_invalid_idx();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
